alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage sitting directly downstream of the 16-bit bit-slice merge in the ALU.
//  Captures each merged result word together with the carry-out of the top slice.
//  Computes zero, negative, carry and signed-overflow flags for that word.
//  Buffers up to 2 result entries behind a valid/ready handshake and keeps a sticky overflow status.
// PARAMETERS
//  WIDTH  16  data width of the merged result; flags are derived from bit WIDTH-1
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous active-low reset
//  in_result    in   WIDTH  merged result word from the merge stage
//  in_cout      in   1      carry-out of the most-significant ALU slice
//  in_a_msb     in   1      operand A bit WIDTH-1
//  in_b_msb     in   1      operand B bit WIDTH-1 (as fed to the adder, before inversion)
//  in_sub       in   1      1 = subtract operation, 0 = add/logic
//  in_valid     in   1      upstream presents a word this cycle
//  in_ready     out  1      stage accepts a word this cycle
//  out_data     out  WIDTH  head-entry result
//  out_zero     out  1      head entry == 0
//  out_neg      out  1      head entry bit WIDTH-1
//  out_carry    out  1      head entry carry-out
//  out_ovf      out  1      head entry signed overflow
//  out_valid    out  1      head entry is valid
//  out_ready    in   1      downstream consumes the head this cycle
//  ovf_sticky   out  1      set by any accepted word with overflow
//  clr_sticky   in   1      synchronous clear of ovf_sticky
// BEHAVIOUR
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready. Storage is 2 entries with occupancy count 0..2.
//  - in_ready = (count != 2), driven from a register. It does not depend combinationally on out_ready.
//  - out_valid = (count != 0). out_* always reflect entry 0 (the head), driven straight from flops.
//  - Flags are computed at push time and stored with the entry:
//    zero = ~|in_result; neg = in_result[WIDTH-1]; carry = in_cout.
//    ovf, add: (a_msb == b_msb) & (res_msb != a_msb).
//    ovf, sub: (a_msb != b_msb) & (res_msb != a_msb).
//  - Latency: a word pushed in cycle N appears on out_* in cycle N+1 when the stage was empty.
//  - Transitions by count:
//    - 0, push: -> 1, head = new word.
//    - 1, push only: -> 2, new word goes to entry 1.
//    - 1, pop only: -> 0.
//    - 1, push & pop: stays 1, head = new word.
//    - 2, pop: -> 1, entry 1 moves to head. No push is possible while count = 2.
//  - When count = 2, in_ready = 0 and upstream must hold in_valid and its data stable.
//  - Pop with count = 0 is impossible (out_valid = 0); out_ready is ignored.
//  - Head registers hold their value whenever no push or pop affects them. Stale data when out_valid = 0 is don't-care.
//  - ovf_sticky: set on a push carrying ovf = 1, cleared by clr_sticky. If both occur in the same cycle, set wins.
//  - Reset (asynchronous, reset_n = 0), including mid-transfer:
//    - count = 0, out_valid = 0, in_ready = 1 (in the first cycle after release).
//    - out_data = 0, all flag outputs = 0, ovf_sticky = 0.
//    - Buffered entries are discarded.
// TESTING
//  1. Reset mid-stream with count = 2: out_valid = 0 and ovf_sticky = 0 immediately; in_ready = 1 after release.
//  2. Push 0x0000 (add, cout = 1), out_ready = 1: the next cycle gives out_data = 0000, zero = 1, carry = 1, neg = 0, ovf = 0.
//  3. Add 0x7FFF + 0x0001: in_result = 0x8000, a_msb = 0, b_msb = 0 -> neg = 1, ovf = 1, ovf_sticky = 1 until clr_sticky.
//  4. Sub 0x8000 - 0x0001: in_result = 0x7FFF, a_msb = 1, b_msb = 0, sub = 1 -> ovf = 1.
//     Sub 0x0005 - 0x0003 -> ovf = 0, result 0x0002.
//  5. Back-pressure: out_ready = 0, push 0x1111 then 0x2222 -> in_ready = 0.
//     Then out_ready = 1 -> 0x1111 then 0x2222 come out in order, and in_ready returns to 1.
//  6. Count = 1, push 0x3333 & pop in the same cycle -> count stays 1 and the head becomes 0x3333.
//     Also check clr_sticky together with an ovf push -> ovf_sticky = 1.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered result stage for the ALU merge output: computes Z/N/C/V flags at capture,
// buffers up to two words behind valid/ready and maintains a sticky overflow bit.
module alu_result_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             in_sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    // Entry layout: {ovf, carry, neg, zero, data}
    localparam int EW = WIDTH + 4;

    logic [EW-1:0] head_reg, head_next;
    logic [EW-1:0] tail_reg, tail_next;
    logic [1:0]    count_reg, count_next;
    logic          in_ready_reg, in_ready_next;
    logic          valid_reg, valid_next;
    logic          sticky_reg, sticky_next;

    logic          push;
    logic          pop;
    logic          res_msb;
    logic          new_zero;
    logic          new_ovf;
    logic [EW-1:0] new_entry;

    assign push = in_valid & in_ready_reg;
    assign pop  = valid_reg & out_ready;

    assign res_msb  = in_result[WIDTH-1];
    assign new_zero = ~|in_result;
    // Subtract feeds ~B to the adder, so the same-sign test flips to a different-sign test.
    assign new_ovf  = in_sub ? ((in_a_msb != in_b_msb) & (res_msb != in_a_msb))
                             : ((in_a_msb == in_b_msb) & (res_msb != in_a_msb));
    assign new_entry = {new_ovf, in_cout, res_msb, new_zero, in_result};

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        case (count_reg)
            2'd0: begin
                if (push) begin
                    head_next  = new_entry;
                    count_next = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_next = new_entry;
                end else if (push) begin
                    tail_next  = new_entry;
                    count_next = 2'd2;
                end else if (pop) begin
                    count_next = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_next  = tail_reg;
                    count_next = 2'd1;
                end
            end
            default: begin
                count_next = 2'd0;
            end
        endcase
    end

    always_comb begin
        in_ready_next = (count_next != 2'd2);
        valid_next    = (count_next != 2'd0);
        sticky_next   = sticky_reg;
        if (push && new_ovf) begin
            sticky_next = 1'b1;
        end else if (clr_sticky) begin
            sticky_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= 2'd0;
            in_ready_reg <= 1'b1;
            valid_reg    <= 1'b0;
            sticky_reg   <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            in_ready_reg <= in_ready_next;
            valid_reg    <= valid_next;
            sticky_reg   <= sticky_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = valid_reg;
    assign ovf_sticky = sticky_reg;
    assign out_data   = head_reg[WIDTH-1:0];
    assign out_zero   = head_reg[WIDTH];
    assign out_neg    = head_reg[WIDTH+1];
    assign out_carry  = head_reg[WIDTH+2];
    assign out_ovf    = head_reg[WIDTH+3];

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: randomized add/sub operands, expected flags from
// integer arithmetic, monitor pops and compares whenever the DUT hands off a word.
module tb_alu_result_stage;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
        logic         neg;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_result;
    logic         in_cout;
    logic         in_a_msb;
    logic         in_b_msb;
    logic         in_sub;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_zero;
    logic         out_neg;
    logic         out_carry;
    logic         out_ovf;
    logic         out_valid;
    logic         out_ready;
    logic         ovf_sticky;
    logic         clr_sticky;

    alu_result_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_result  (in_result),
        .in_cout    (in_cout),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .in_sub     (in_sub),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks = 0;
    int   errors = 0;
    logic exp_sticky = 1'b0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                   output logic [W-1:0] res, output logic cout);
        exp_t e;
        int   ua, ub, us, sa, sb_i, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb_i = int'($signed(b));
        if (sub) begin
            us = ua + (65535 - ub) + 1;
            sr = sa - sb_i;
        end else begin
            us = ua + ub;
            sr = sa + sb_i;
        end
        res     = us[W-1:0];
        cout    = (us >= 65536);
        e.data  = res;
        e.zero  = (res == 0);
        e.neg   = (sr < 0 && sr >= -32768) || (sr > 32767);
        e.carry = cout;
        e.ovf   = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ordy, input logic clr, output logic acc);
        exp_t         e;
        logic [W-1:0] r;
        logic         c;
        @(negedge clk);
        chk("ovf_sticky", ovf_sticky, exp_sticky);
        e          = model(a, b, sub, r, c);
        in_valid   = v;
        in_result  = r;
        in_cout    = c;
        in_a_msb   = a[W-1];
        in_b_msb   = b[W-1];
        in_sub     = sub;
        out_ready  = ordy;
        clr_sticky = clr;
        #1;
        acc = v && in_ready;
        if (acc) begin
            sb.push_back(e);
            $display("push a=%h b=%h sub=%0d -> res=%h z=%0d n=%0d c=%0d v=%0d",
                     a, b, sub, e.data, e.zero, e.neg, e.carry, e.ovf);
        end
        if (acc && e.ovf) exp_sticky = 1'b1;
        else if (clr)     exp_sticky = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic ordy, input logic clr);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        cycle(1'b1, a, b, sub, ordy, clr, acc);
        while (!acc && n < 50) begin
            cycle(1'b1, a, b, sub, (n >= 4) ? 1'b1 : 1'($urandom_range(0, 1)), clr, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %0d, required 1", in_ready);
        end
    endtask

    task automatic idle(input int n, input logic ordy, input logic clr);
        logic acc;
        repeat (n) cycle(1'b0, '0, '0, 1'b0, ordy, clr, acc);
    endtask

    // Monitor: a handoff happens at the next edge whenever out_valid & out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got data %h, required no output", out_data);
                end else begin
                    e = sb.pop_front();
                    $display("pop data=%h z=%0d n=%0d c=%0d v=%0d",
                             out_data, out_zero, out_neg, out_carry, out_ovf);
                    chk("out_data",  out_data,  e.data);
                    chk("out_zero",  out_zero,  e.zero);
                    chk("out_neg",   out_neg,   e.neg);
                    chk("out_carry", out_carry, e.carry);
                    chk("out_ovf",   out_ovf,   e.ovf);
                end
            end
        end
    end

    logic [W-1:0] corners [6];

    initial begin
        logic [W-1:0] a, b;
        int           n;
        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
        corners[3] = 16'h8000; corners[4] = 16'hFFFF; corners[5] = 16'h8001;

        reset_n = 1'b0; in_valid = 1'b0; in_result = '0; in_cout = 1'b0;
        in_a_msb = 1'b0; in_b_msb = 1'b0; in_sub = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        idle(1, 1'b0, 1'b0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_zero, out_neg, out_carry, out_ovf}, 0);

        // Zero result with carry, one-cycle latency
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b0);
        chk("lat_valid", out_valid, 1);
        chk("t2_data", out_data, 16'h0000);
        chk("t2_zc", {out_zero, out_carry, out_neg, out_ovf}, 4'b1100);

        // Positive add overflow and sticky
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b0);
        chk("t3_neg_ovf", {out_neg, out_ovf}, 2'b11);
        idle(3, 1'b1, 1'b0);
        chk("t3_sticky_hold", ovf_sticky, 1);
        idle(1, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b0);

        // Subtract overflow / no overflow
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b0);
        chk("t4_sub_data", out_data, 16'h7FFF);
        chk("t4_sub_ovf", out_ovf, 1);
        send(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b0);
        chk("t4_sub2_data", out_data, 16'h0002);
        chk("t4_sub2_ovf", out_ovf, 0);
        idle(1, 1'b1, 1'b1);

        // Back-pressure fills both entries
        idle(2, 1'b1, 1'b0);
        send(16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        chk("t5_full_in_ready", in_ready, 0);
        chk("t5_head", out_data, 16'h1111);
        idle(2, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b0);
        chk("t5_in_ready_back", in_ready, 1);
        chk("t5_empty", out_valid, 0);

        // Simultaneous push and pop at count 1
        send(16'h4444, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(16'h3333, 16'h0000, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b0);
        chk("t6_head", out_data, 16'h3333);
        chk("t6_valid", out_valid, 1);
        chk("t6_in_ready", in_ready, 1);
        idle(1, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b0);
        chk("t6_one_entry", out_valid, 0);

        // Set wins over clear
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b0);
        chk("t6_set_wins", ovf_sticky, 1);
        idle(1, 1'b1, 1'b1);

        // Reset while full
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        chk("t1_full", in_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_rst_valid", out_valid, 0);
        chk("t1_rst_sticky", ovf_sticky, 0);
        chk("t1_rst_data", out_data, 0);
        sb.delete();
        exp_sticky = 1'b0;
        idle(2, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        idle(1, 1'b0, 1'b0);
        chk("t1_in_ready_after", in_ready, 1);
        chk("t1_valid_after", out_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            if ($urandom_range(0, 4) == 0)
                idle(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
            else
                send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 7) == 0));
        end

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            idle(1, 1'b1, 1'b0);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        idle(1, 1'b1, 1'b0);
        chk("drain_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
